// File: rtl/vga_pkg.sv
// Shared definitions for the 640x480@60 Hz VGA display-timing path.
// Holds the default timing constants, the idle coordinate value, the RGB565
// pixel type, the FSM state encoding and the test colour-bar palette.
package vga_pkg;

    localparam int H_SYNC_DFLT   = 96;
    localparam int H_BACK_DFLT   = 48;
    localparam int H_ACTIVE_DFLT = 640;
    localparam int H_FRONT_DFLT  = 16;
    localparam int H_TOTAL       = H_SYNC_DFLT + H_BACK_DFLT + H_ACTIVE_DFLT + H_FRONT_DFLT;

    localparam int V_SYNC_DFLT   = 2;
    localparam int V_BACK_DFLT   = 33;
    localparam int V_ACTIVE_DFLT = 480;
    localparam int V_FRONT_DFLT  = 10;
    localparam int V_TOTAL       = V_SYNC_DFLT + V_BACK_DFLT + V_ACTIVE_DFLT + V_FRONT_DFLT;

    // Coordinate driven to the generator when no pixel is being requested.
    localparam logic [9:0] COORD_IDLE = 10'h3ff;

    typedef logic [15:0] rgb565_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } vga_state_e;

    localparam rgb565_t BAR_WHITE   = 16'hFFFF;
    localparam rgb565_t BAR_YELLOW  = 16'hFFE0;
    localparam rgb565_t BAR_CYAN    = 16'h07FF;
    localparam rgb565_t BAR_GREEN   = 16'h07E0;
    localparam rgb565_t BAR_MAGENTA = 16'hF81F;
    localparam rgb565_t BAR_RED     = 16'hF800;
    localparam rgb565_t BAR_BLUE    = 16'h001F;
    localparam rgb565_t BAR_BLACK   = 16'h0000;

    // Colour of bar number idx, counted left to right.
    function automatic rgb565_t bar_colour(input logic [2:0] idx);
        rgb565_t c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_scan_cnt.sv
// Horizontal/vertical scan counters for the VGA timing controller.
// Ports:
//   clk_i         pixel clock
//   rst_i         synchronous active-high reset (counters to 0)
//   hold_i        hold both counters at 0 (controller idle)
//   cnt_h_nxt_o   value cnt_h takes at the next clock
//   cnt_v_nxt_o   value cnt_v takes at the next clock
//   frame_wrap_o  current position is the last pixel of the frame
// The next-state values are exported so the controller can register its
// outputs in step with the counters instead of one clock behind them.
module vga_scan_cnt #(
    parameter int H_TOT = 800,
    parameter int V_TOT = 525
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       hold_i,
    output logic [9:0] cnt_h_nxt_o,
    output logic [9:0] cnt_v_nxt_o,
    output logic       frame_wrap_o
);

    localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOT - 1);

    logic [9:0] cnt_h_q, cnt_h_d;
    logic [9:0] cnt_v_q, cnt_v_d;
    logic       line_wrap;

    assign line_wrap    = (cnt_h_q == H_LAST);
    assign frame_wrap_o = line_wrap && (cnt_v_q == V_LAST);

    always_comb begin
        cnt_h_d = cnt_h_q + 10'd1;
        cnt_v_d = cnt_v_q;
        if (hold_i) begin
            cnt_h_d = '0;
            cnt_v_d = '0;
        end else if (line_wrap) begin
            cnt_h_d = '0;
            cnt_v_d = (cnt_v_q == V_LAST) ? 10'd0 : cnt_v_q + 10'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_h_q <= '0;
            cnt_v_q <= '0;
        end else begin
            cnt_h_q <= cnt_h_d;
            cnt_v_q <= cnt_v_d;
        end
    end

    assign cnt_h_nxt_o = cnt_h_d;
    assign cnt_v_nxt_o = cnt_v_d;

endmodule

// File: rtl/vga_ctrl.sv
// VGA display-timing controller (640x480@60 Hz by default).
// Runs the scan counters, requests pixels from the picture generator ahead of
// the visible window by PIX_LAT clocks, and gates the returned pixel onto rgb.
// Ports:
//   vga_clk      pixel clock (25 MHz)
//   sys_rst      synchronous active-high reset
//   vga_en       scan enable, acted on at frame granularity
//   pix_data     RGB565 pixel from the generator, PIX_LAT clocks after pix_x/pix_y
//   bar_sel      (only with VGA_CTRL_TEST_BAR_EN) colour-bar test pattern select
//   pix_x/pix_y  requested coordinate, 10'h3ff when not requesting
//   hsync/vsync  sync pulses, active high
//   rgb          pixel to DAC, 0 outside the visible window
//   rgb_valid    high inside the visible window
//   frame_start  one-clock pulse at cnt_h=0, cnt_v=0 of each scanned frame
// Optional feature macro: VGA_CTRL_TEST_BAR_EN.
//
// state | meaning
// IDLE  | counters held at 0, outputs at reset values
// RUN   | scanning frames continuously
// DRAIN | enable dropped; finishing the current frame
//
// Registered outputs are loaded from the next state and next counter values,
// so every output is aligned with the counter position it describes.
module vga_ctrl
    import vga_pkg::*;
#(
    parameter int H_SYNC   = H_SYNC_DFLT,
    parameter int H_BACK   = H_BACK_DFLT,
    parameter int H_ACTIVE = H_ACTIVE_DFLT,
    parameter int H_FRONT  = H_FRONT_DFLT,
    parameter int V_SYNC   = V_SYNC_DFLT,
    parameter int V_BACK   = V_BACK_DFLT,
    parameter int V_ACTIVE = V_ACTIVE_DFLT,
    parameter int V_FRONT  = V_FRONT_DFLT,
    parameter int PIX_LAT  = 1
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic        vga_en,
    input  logic [15:0] pix_data,
`ifdef VGA_CTRL_TEST_BAR_EN
    input  logic        bar_sel,
`endif
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic [15:0] rgb,
    output logic        rgb_valid,
    output logic        frame_start
);

    localparam int H_TOT = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOT = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [9:0] HS_END   = 10'(H_SYNC);
    localparam logic [9:0] VS_END   = 10'(V_SYNC);
    localparam logic [9:0] H_VIS_LO = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_VIS_HI = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0] H_REQ_LO = 10'(H_SYNC + H_BACK - PIX_LAT);
    localparam logic [9:0] H_REQ_HI = 10'(H_SYNC + H_BACK + H_ACTIVE - PIX_LAT);
    localparam logic [9:0] V_VIS_LO = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_VIS_HI = 10'(V_SYNC + V_BACK + V_ACTIVE);

    if (PIX_LAT < 1 || PIX_LAT > 4) begin : g_bad_lat
        $error("vga_ctrl: PIX_LAT must be in 1..4");
    end
    if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_total
        $error("vga_ctrl: timing totals must fit 10-bit counters");
    end

    vga_state_e state_q, state_d;
    logic [9:0] cnt_h_nxt, cnt_v_nxt;
    logic       frame_wrap;

    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       valid_q, valid_d;
    logic       fs_q, fs_d;
    logic [9:0] pix_x_q, pix_x_d;
    logic [9:0] pix_y_q, pix_y_d;

    vga_scan_cnt #(
        .H_TOT (H_TOT),
        .V_TOT (V_TOT)
    ) u_scan_cnt (
        .clk_i        (vga_clk),
        .rst_i        (sys_rst),
        .hold_i       (state_q == IDLE),
        .cnt_h_nxt_o  (cnt_h_nxt),
        .cnt_v_nxt_o  (cnt_v_nxt),
        .frame_wrap_o (frame_wrap)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (vga_en) state_d = RUN;
            RUN:     if (!vga_en) state_d = DRAIN;
            DRAIN:   if (frame_wrap) state_d = vga_en ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic scan_on, v_vis, h_vis, h_req, req;

    always_comb begin
        scan_on = (state_d != IDLE);
        v_vis   = (cnt_v_nxt >= V_VIS_LO) && (cnt_v_nxt < V_VIS_HI);
        h_vis   = (cnt_h_nxt >= H_VIS_LO) && (cnt_h_nxt < H_VIS_HI);
        h_req   = (cnt_h_nxt >= H_REQ_LO) && (cnt_h_nxt < H_REQ_HI);
        req     = scan_on && v_vis && h_req;

        hsync_d = scan_on && (cnt_h_nxt < HS_END);
        vsync_d = scan_on && (cnt_v_nxt < VS_END);
        valid_d = scan_on && v_vis && h_vis;
        fs_d    = scan_on && (cnt_h_nxt == 10'd0) && (cnt_v_nxt == 10'd0);
        pix_x_d = req ? (cnt_h_nxt - H_REQ_LO) : COORD_IDLE;
        pix_y_d = req ? (cnt_v_nxt - V_VIS_LO) : COORD_IDLE;
    end

`ifdef VGA_CTRL_TEST_BAR_EN
    localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

    rgb565_t    bar_rgb_q, bar_rgb_d;
    logic [9:0] bar_off, bar_idx;

    // Only meaningful inside the visible window; rgb is gated elsewhere.
    always_comb begin
        bar_off   = cnt_h_nxt - H_VIS_LO;
        bar_idx   = bar_off / BAR_W;
        bar_rgb_d = bar_colour(bar_idx[2:0]);
    end
`endif

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
            valid_q   <= 1'b0;
            fs_q      <= 1'b0;
            pix_x_q   <= COORD_IDLE;
            pix_y_q   <= COORD_IDLE;
`ifdef VGA_CTRL_TEST_BAR_EN
            bar_rgb_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            valid_q   <= valid_d;
            fs_q      <= fs_d;
            pix_x_q   <= pix_x_d;
            pix_y_q   <= pix_y_d;
`ifdef VGA_CTRL_TEST_BAR_EN
            bar_rgb_q <= bar_rgb_d;
`endif
        end
    end

    // pix_data comes from the generator's own register stage, already aligned
    // with valid_q by the early request window, so it is gated directly.
`ifdef VGA_CTRL_TEST_BAR_EN
    assign rgb = !valid_q ? 16'h0 : (bar_sel ? bar_rgb_q : pix_data);
`else
    assign rgb = valid_q ? pix_data : 16'h0;
`endif

    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb_valid   = valid_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_ctrl.sv
// Self-checking bench for vga_ctrl.
// dut_a: full 640x480 timing, PIX_LAT=1, early lines of the first frame.
// dut_b/dut_c: reduced timing (28x13 clocks/lines) with PIX_LAT=1 and 3, used
// for whole-frame behaviour (period, drain, re-enable, mid-frame reset).
module tb_vga_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, en_a, rst_s, en_s;
`ifdef VGA_CTRL_TEST_BAR_EN
    logic bar_a, bar_s;
`endif

    logic [15:0] pd_a, pd_b, pd_c, pc_s1, pc_s2;
    logic [9:0]  px_a, py_a, px_b, py_b, px_c, py_c;
    logic        hs_a, vs_a, val_a, fs_a;
    logic        hs_b, vs_b, val_b, fs_b;
    logic        hs_c, vs_c, val_c, fs_c;
    logic [15:0] rgb_a, rgb_b, rgb_c;

    vga_ctrl #(.PIX_LAT(1)) dut_a (
        .vga_clk(clk), .sys_rst(rst_a), .vga_en(en_a), .pix_data(pd_a),
`ifdef VGA_CTRL_TEST_BAR_EN
        .bar_sel(bar_a),
`endif
        .pix_x(px_a), .pix_y(py_a), .hsync(hs_a), .vsync(vs_a),
        .rgb(rgb_a), .rgb_valid(val_a), .frame_start(fs_a));

    vga_ctrl #(.H_SYNC(4), .H_BACK(4), .H_ACTIVE(16), .H_FRONT(4),
               .V_SYNC(2), .V_BACK(3), .V_ACTIVE(6), .V_FRONT(2), .PIX_LAT(1)) dut_b (
        .vga_clk(clk), .sys_rst(rst_s), .vga_en(en_s), .pix_data(pd_b),
`ifdef VGA_CTRL_TEST_BAR_EN
        .bar_sel(bar_s),
`endif
        .pix_x(px_b), .pix_y(py_b), .hsync(hs_b), .vsync(vs_b),
        .rgb(rgb_b), .rgb_valid(val_b), .frame_start(fs_b));

    vga_ctrl #(.H_SYNC(4), .H_BACK(4), .H_ACTIVE(16), .H_FRONT(4),
               .V_SYNC(2), .V_BACK(3), .V_ACTIVE(6), .V_FRONT(2), .PIX_LAT(3)) dut_c (
        .vga_clk(clk), .sys_rst(rst_s), .vga_en(en_s), .pix_data(pd_c),
`ifdef VGA_CTRL_TEST_BAR_EN
        .bar_sel(bar_s),
`endif
        .pix_x(px_c), .pix_y(py_c), .hsync(hs_c), .vsync(vs_c),
        .rgb(rgb_c), .rgb_valid(val_c), .frame_start(fs_c));

    // Behavioural generators: pixel = {y[5:0], x[9:0]}, 1 and 3 register stages.
    always_ff @(posedge clk) begin
        pd_a  <= {py_a[5:0], px_a};
        pd_b  <= {py_b[5:0], px_b};
        pc_s1 <= {py_c[5:0], px_c};
        pc_s2 <= pc_s1;
        pd_c  <= pc_s2;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int ka = 0, ks = 0;
    int hs_cnt = 0, vs_cnt = 0;

    typedef struct {
        int h; int v;
        logic hs; logic vs; logic val; logic [15:0] rgb;
        logic [9:0] px; logic [9:0] py; logic fs;
    } vec_a_t;

    typedef struct {
        int h; int v;
        logic hs; logic vs; logic val; logic [15:0] rgb;
        logic [9:0] px_b; logic [9:0] py_b; logic [9:0] px_c; logic [9:0] py_c;
    } vec_s_t;

    vec_a_t tbl_a[15];
    vec_s_t tbl_s[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic adv_a(input int target);
        while (ka < target) begin
            tick();
            ka++;
            if (ka < 800)  hs_cnt += int'(hs_a);
            if (ka < 2400) vs_cnt += int'(vs_a);
        end
    endtask

    task automatic adv_s(input int target);
        while (ks < target) begin
            tick();
            ks++;
        end
    endtask

    task automatic wait_fs(input string name, input int exp_period);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!fs_b && n < 1000);
        check(name, n, exp_period);
        ks = 0;
    endtask

    task automatic check_idle_b(input string name);
        check({name, ".hsync"}, hs_b, 1'b0);
        check({name, ".vsync"}, vs_b, 1'b0);
        check({name, ".rgb_valid"}, val_b, 1'b0);
        check({name, ".rgb"}, rgb_b, 16'h0);
        check({name, ".pix_x"}, px_b, 10'h3ff);
        check({name, ".pix_y"}, py_b, 10'h3ff);
        check({name, ".frame_start"}, fs_b, 1'b0);
        check({name, ".c_pix_x"}, px_c, 10'h3ff);
    endtask

    initial begin
        //          h    v   hs vs val rgb       px      py      fs
        tbl_a[0]  = '{0,   0,  1, 1, 0, 16'h0000, 10'h3ff, 10'h3ff, 1};
        tbl_a[1]  = '{1,   0,  1, 1, 0, 16'h0000, 10'h3ff, 10'h3ff, 0};
        tbl_a[2]  = '{95,  0,  1, 1, 0, 16'h0000, 10'h3ff, 10'h3ff, 0};
        tbl_a[3]  = '{96,  0,  0, 1, 0, 16'h0000, 10'h3ff, 10'h3ff, 0};
        tbl_a[4]  = '{0,   1,  1, 1, 0, 16'h0000, 10'h3ff, 10'h3ff, 0};
        tbl_a[5]  = '{0,   2,  1, 0, 0, 16'h0000, 10'h3ff, 10'h3ff, 0};
        tbl_a[6]  = '{142, 35, 0, 0, 0, 16'h0000, 10'h3ff, 10'h3ff, 0};
        tbl_a[7]  = '{143, 35, 0, 0, 0, 16'h0000, 10'd0,   10'd0,   0};
        tbl_a[8]  = '{144, 35, 0, 0, 1, 16'h0000, 10'd1,   10'd0,   0};
        tbl_a[9]  = '{145, 35, 0, 0, 1, 16'h0001, 10'd2,   10'd0,   0};
        tbl_a[10] = '{782, 35, 0, 0, 1, 16'h027E, 10'd639, 10'd0,   0};
        tbl_a[11] = '{783, 35, 0, 0, 1, 16'h027F, 10'h3ff, 10'h3ff, 0};
        tbl_a[12] = '{784, 35, 0, 0, 0, 16'h0000, 10'h3ff, 10'h3ff, 0};
        tbl_a[13] = '{143, 36, 0, 0, 0, 16'h0000, 10'd0,   10'd1,   0};
        tbl_a[14] = '{144, 36, 0, 0, 1, 16'h0400, 10'd1,   10'd1,   0};

        //          h   v   hs vs val rgb       px_b     py_b     px_c     py_c
        tbl_s[0]  = '{3,  1,  1, 1, 0, 16'h0000, 10'h3ff, 10'h3ff, 10'h3ff, 10'h3ff};
        tbl_s[1]  = '{4,  2,  0, 0, 0, 16'h0000, 10'h3ff, 10'h3ff, 10'h3ff, 10'h3ff};
        tbl_s[2]  = '{7,  4,  0, 0, 0, 16'h0000, 10'h3ff, 10'h3ff, 10'h3ff, 10'h3ff};
        tbl_s[3]  = '{4,  5,  0, 0, 0, 16'h0000, 10'h3ff, 10'h3ff, 10'h3ff, 10'h3ff};
        tbl_s[4]  = '{5,  5,  0, 0, 0, 16'h0000, 10'h3ff, 10'h3ff, 10'd0,   10'd0};
        tbl_s[5]  = '{7,  5,  0, 0, 0, 16'h0000, 10'd0,   10'd0,   10'd2,   10'd0};
        tbl_s[6]  = '{8,  5,  0, 0, 1, 16'h0000, 10'd1,   10'd0,   10'd3,   10'd0};
        tbl_s[7]  = '{9,  5,  0, 0, 1, 16'h0001, 10'd2,   10'd0,   10'd4,   10'd0};
        tbl_s[8]  = '{20, 5,  0, 0, 1, 16'h000C, 10'd13,  10'd0,   10'd15,  10'd0};
        tbl_s[9]  = '{21, 5,  0, 0, 1, 16'h000D, 10'd14,  10'd0,   10'h3ff, 10'h3ff};
        tbl_s[10] = '{23, 10, 0, 0, 1, 16'h140F, 10'h3ff, 10'h3ff, 10'h3ff, 10'h3ff};
        tbl_s[11] = '{24, 10, 0, 0, 0, 16'h0000, 10'h3ff, 10'h3ff, 10'h3ff, 10'h3ff};
        tbl_s[12] = '{8,  11, 0, 0, 0, 16'h0000, 10'h3ff, 10'h3ff, 10'h3ff, 10'h3ff};

        rst_a = 1'b1; en_a = 1'b0; rst_s = 1'b1; en_s = 1'b0;
`ifdef VGA_CTRL_TEST_BAR_EN
        bar_a = 1'b0; bar_s = 1'b0;
`endif
        tick(); tick();

        // Full-size timing: reset state, idle hold, then the table.
        check("a_rst.hsync", hs_a, 1'b0);
        check("a_rst.vsync", vs_a, 1'b0);
        check("a_rst.rgb_valid", val_a, 1'b0);
        check("a_rst.pix_x", px_a, 10'h3ff);
        check("a_rst.pix_y", py_a, 10'h3ff);
        check("a_rst.frame_start", fs_a, 1'b0);
        rst_a = 1'b0;
        tick(); tick();
        check("a_idle.hsync", hs_a, 1'b0);
        check("a_idle.frame_start", fs_a, 1'b0);
        en_a = 1'b1;
        tick();
        ka = 0;
        hs_cnt = int'(hs_a);
        vs_cnt = int'(vs_a);
        for (int i = 0; i < 15; i++) begin
            adv_a(tbl_a[i].v * 800 + tbl_a[i].h);
            check($sformatf("a%0d.hsync", i), hs_a, tbl_a[i].hs);
            check($sformatf("a%0d.vsync", i), vs_a, tbl_a[i].vs);
            check($sformatf("a%0d.rgb_valid", i), val_a, tbl_a[i].val);
            check($sformatf("a%0d.rgb", i), rgb_a, tbl_a[i].rgb);
            check($sformatf("a%0d.pix_x", i), px_a, tbl_a[i].px);
            check($sformatf("a%0d.pix_y", i), py_a, tbl_a[i].py);
            check($sformatf("a%0d.frame_start", i), fs_a, tbl_a[i].fs);
        end
        check("a_hsync_clocks_per_line", hs_cnt, 96);
        check("a_vsync_clocks_first_3_lines", vs_cnt, 1600);

`ifdef VGA_CTRL_TEST_BAR_EN
        bar_a = 1'b1;
        adv_a(37 * 800 + 143); check("bar.h143", rgb_a, 16'h0000);
        adv_a(37 * 800 + 144); check("bar.x0", rgb_a, 16'hFFFF);
        adv_a(37 * 800 + 223); check("bar.x79", rgb_a, 16'hFFFF);
        adv_a(37 * 800 + 224); check("bar.x80", rgb_a, 16'hFFE0);
        adv_a(37 * 800 + 624); check("bar.x480", rgb_a, 16'h001F);
        adv_a(37 * 800 + 783); check("bar.x639", rgb_a, 16'h0000);
        check("bar.x639_valid", val_a, 1'b1);
        check("bar.x639_pix_x_driven", px_a, 10'h3ff);
        adv_a(37 * 800 + 782); // no-op guard: already past
        adv_a(37 * 800 + 784); check("bar.h784", rgb_a, 16'h0000);
        check("bar.h784_valid", val_a, 1'b0);
        bar_a = 1'b0;
`endif
        en_a = 1'b0;

        // Reduced timing: 28 clocks/line, 13 lines, 364 clocks/frame.
        tick();
        check_idle_b("s_rst");
        rst_s = 1'b0;
        tick(); tick(); tick();
        check_idle_b("s_idle");
        en_s = 1'b1;
        tick();
        ks = 0;
        check("s_start.frame_start", fs_b, 1'b1);
        check("s_start.hsync", hs_b, 1'b1);
        check("s_start.vsync", vs_b, 1'b1);
        check("s_start.c_frame_start", fs_c, 1'b1);
        adv_s(1);
        check("s_k1.frame_start", fs_b, 1'b0);
        for (int i = 0; i < 13; i++) begin
            adv_s(tbl_s[i].v * 28 + tbl_s[i].h);
            check($sformatf("s%0d.hsync", i), hs_b, tbl_s[i].hs);
            check($sformatf("s%0d.vsync", i), vs_b, tbl_s[i].vs);
            check($sformatf("s%0d.rgb_valid_b", i), val_b, tbl_s[i].val);
            check($sformatf("s%0d.rgb_valid_c", i), val_c, tbl_s[i].val);
            check($sformatf("s%0d.rgb_b", i), rgb_b, tbl_s[i].rgb);
            check($sformatf("s%0d.rgb_c", i), rgb_c, tbl_s[i].rgb);
            check($sformatf("s%0d.pix_x_b", i), px_b, tbl_s[i].px_b);
            check($sformatf("s%0d.pix_y_b", i), py_b, tbl_s[i].py_b);
            check($sformatf("s%0d.pix_x_c", i), px_c, tbl_s[i].px_c);
            check($sformatf("s%0d.pix_y_c", i), py_c, tbl_s[i].py_c);
        end
        wait_fs("s_frame_period", 364 - ks);

        // Enable dropped and restored inside one frame: next frame follows with no gap.
        adv_s(84);
        en_s = 1'b0;
        adv_s(5 * 28 + 8);
        check("drain_run.rgb_valid", val_b, 1'b1);
        adv_s(9 * 28);
        en_s = 1'b1;
        wait_fs("drain_run.period", 364 - ks);

        // Enable dropped at line 7: frame completes, then idle.
        adv_s(7 * 28);
        en_s = 1'b0;
        adv_s(8 * 28 + 9);
        check("drain.rgb_valid", val_b, 1'b1);
        check("drain.rgb", rgb_b, 16'h0C01);
        adv_s(363);
        check("drain.last_frame_start", fs_b, 1'b0);
        adv_s(364);
        check_idle_b("drain_end");
        adv_s(366);
        check("drain_idle.hsync", hs_b, 1'b0);
        check("drain_idle.frame_start", fs_b, 1'b0);
        en_s = 1'b1;
        tick();
        ks = 0;
        check("reen.frame_start", fs_b, 1'b1);
        check("reen.hsync", hs_b, 1'b1);

        // Reset mid-frame at cnt_h=10, cnt_v=7.
        adv_s(7 * 28 + 10);
        check("prerst.rgb", rgb_b, 16'h0802);
        check("prerst.pix_x", px_b, 10'd3);
        rst_s = 1'b1;
        tick();
        check_idle_b("midrst");
        rst_s = 1'b0;
        tick();
        ks = 0;
        check("postrst.frame_start", fs_b, 1'b1);
        check("postrst.hsync", hs_b, 1'b1);
        adv_s(5 * 28 + 8);
        check("postrst.first_pixel_valid", val_b, 1'b1);
        check("postrst.first_pixel_rgb", rgb_b, 16'h0000);
        check("postrst.c_rgb", rgb_c, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
